program_loader: RTL and testbench

Boot-time writer for the Hack instruction memory. It accepts a byte stream from a serial receiver, assembles big-endian 16-bit instruction words, and writes them to consecutive ROM addresses starting at 0. It holds the CPU in reset until the image is complete. It sits between the UART receive path and the instruction-memory write port, ahead of the computer top level.

---
 rtl/program_loader.sv | 186 ++++++++++++++++++
 tb/tb_program_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-time loader: byte stream -> big-endian 16-bit words -> instruction ROM, CPU held in reset.
// Optional trailing checksum enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_req,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    StLenHi, StLenLo, StDataHi, StDataLo, StCsumHi, StCsumLo, StDone, StError
  } state_e;
`else
  typedef enum logic [2:0] {
    StLenHi, StLenLo, StDataHi, StDataLo, StDone, StError
  } state_e;
`endif

  localparam int unsigned MaxWords = 32'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic              in_ready_q, in_ready_d;
  logic              rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]       rom_data_q, rom_data_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]       sum_q, sum_d;
`endif

  logic        accept;
  logic [15:0] word;
  logic [15:0] n_len;
  logic        last_word;

  // in_ready_q always mirrors "state is a receive state", so it gates acceptance.
  assign accept    = in_valid && in_ready_q;
  assign word      = {hi_q, in_data};
  assign n_len     = {len_q[15:8], in_data};
  assign last_word = (32'(idx_q) + 32'd1) == 32'(len_q);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    hi_d       = hi_q;
    idx_d      = idx_q;
    rom_we_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    unique case (state_q)
      StLenHi: begin
        if (accept) begin
          len_d[15:8] = in_data;
          state_d     = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d = n_len;
          if (n_len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = StCsumHi;
`else
            state_d = StDone;
`endif
          end else if (32'(n_len) > MaxWords) begin
            state_d = StError;
          end else begin
            state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        if (accept) begin
          hi_d    = in_data;
          state_d = StDataLo;
        end
      end
      StDataLo: begin
        if (accept) begin
          rom_we_d   = 1'b1;
          rom_addr_d = idx_q[ADDR_W-1:0];
          rom_data_d = word;
          idx_d      = idx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = sum_q + word;
          state_d    = last_word ? StCsumHi : StDataHi;
`else
          state_d    = last_word ? StDone : StDataHi;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCsumHi: begin
        if (accept) begin
          hi_d    = in_data;
          state_d = StCsumLo;
        end
      end
      StCsumLo: begin
        if (accept) begin
          state_d = (word == sum_q) ? StDone : StError;
        end
      end
`endif
      StDone, StError: begin
        if (load_req) begin
          state_d = StLenHi;
          idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      default: state_d = StLenHi;
    endcase

    in_ready_d  = !((state_d == StDone) || (state_d == StError));
    // Release lags entry to DONE by one cycle so the last ROM write lands first.
    done_d      = (state_q == StDone) && !load_req;
    error_d     = (state_d == StError);
    cpu_reset_d = !done_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StLenHi;
      len_q       <= '0;
      hi_q        <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_data_q  <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_data_q  <= rom_data_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign rom_we    = rom_we_q;
  assign rom_addr  = rom_addr_q;
  assign rom_data  = rom_data_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; inputs change and outputs are sampled on the falling edge.
module tb_program_loader;

  localparam int unsigned ADDR_W = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              load_req;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              cpu_reset;
  logic              done;
  logic              error;

  int n_checks = 0;
  int n_errors = 0;

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .load_req  (load_req),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set(input logic v, input logic [7:0] d, input logic lr);
    in_valid = v;
    in_data  = d;
    load_req = lr;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    set(1'b1, d, 1'b0);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"}, in_ready, 1);
    check({tag, "_we"}, rom_we, 0);
    check({tag, "_addr"}, rom_addr, 0);
    check({tag, "_data"}, rom_data, 0);
    check({tag, "_cpurst"}, cpu_reset, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, error, 0);
  endtask

  task automatic reload();
    set(1'b0, 8'h00, 1'b1);
    tick();
    set(1'b0, 8'h00, 1'b0);
  endtask

  logic [7:0]  bq[$];
  logic [15:0] ed1[4] = '{16'h0002, 16'hEC10, 16'h0003, 16'hE090};
  logic [7:0]  b5[7]  = '{8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
  logic [15:0] ed5[2] = '{16'hA1B2, 16'hC3D4};

  initial begin
    reset = 1'b1;
    set(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    check_reset_outputs("rst");
    reset = 1'b0;

    // Four-word image streamed without gaps.
    bq = '{8'h00, 8'h04, 8'h00, 8'h02, 8'hEC, 8'h10, 8'h00, 8'h03, 8'hE0, 8'h90};
`ifdef LOADER_CHECKSUM_EN
    bq.push_back(8'hCC);
    bq.push_back(8'hA5);
`endif
    for (int i = 0; i < bq.size(); i++) begin
      send(bq[i]);
      if (i >= 3 && i <= 9 && (i % 2) == 1) begin
        check("t1_we", rom_we, 1);
        check("t1_addr", rom_addr, (i - 3) / 2);
        check("t1_data", rom_data, ed1[(i - 3) / 2]);
      end else begin
        check("t1_we0", rom_we, 0);
      end
      check("t1_rdy", in_ready, (i != bq.size() - 1));
      check("t1_cpurst", cpu_reset, 1);
      check("t1_done0", done, 0);
    end
    set(1'b0, 8'h00, 1'b0);
    tick();
    check("t1_we_end", rom_we, 0);
    check("t1_done", done, 1);
    check("t1_cpurst_rel", cpu_reset, 0);
    check("t1_addr_hold", rom_addr, 3);
    check("t1_data_hold", rom_data, 16'hE090);
    check("t1_rdy_done", in_ready, 0);

    // Reload requested together with a byte: byte must not be consumed.
    set(1'b1, 8'h80, 1'b1);
    tick();
    set(1'b0, 8'h00, 1'b0);
    check("lr_done", done, 0);
    check("lr_cpurst", cpu_reset, 1);
    check("lr_rdy", in_ready, 1);

    // Empty image.
    send(8'h00);
    send(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00);
    send(8'h00);
`endif
    check("t2_we", rom_we, 0);
    check("t2_done0", done, 0);
    check("t2_rdy", in_ready, 0);
    set(1'b0, 8'h00, 1'b0);
    tick();
    check("t2_done", done, 1);
    check("t2_cpurst", cpu_reset, 0);
    check("t2_we_end", rom_we, 0);
    reload();

    // Oversized header: 0x8001 > 2^15.
    send(8'h80);
    send(8'h01);
    check("t3_err", error, 1);
    check("t3_rdy", in_ready, 0);
    check("t3_cpurst", cpu_reset, 1);
    send(8'h55);
    check("t3_err_hold", error, 1);
    check("t3_rdy_hold", in_ready, 0);
    check("t3_done", done, 0);
    reload();
    check("t3_err_clr", error, 0);
    check("t3_rdy_clr", in_ready, 1);
    check("t3_cpurst_clr", cpu_reset, 1);

    // Gapped 3-word load abandoned by reset between DATA_HI and DATA_LO.
    for (int i = 0; i < 7; i++) begin
      set(1'b0, 8'hFF, 1'b0);
      tick();
      check("t5_idle_we", rom_we, 0);
      send(b5[i]);
      if (i == 3 || i == 5) begin
        check("t5_we", rom_we, 1);
        check("t5_addr", rom_addr, (i - 3) / 2);
        check("t5_data", rom_data, ed5[(i - 3) / 2]);
      end else begin
        check("t5_we0", rom_we, 0);
      end
    end
    set(1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    #1;
    check_reset_outputs("t5_rst");
    tick();
    reset = 1'b0;

    // Fresh one-word image after the abandoned one.
    send(8'h00);
    send(8'h01);
    send(8'h12);
    send(8'h34);
    check("t6_we", rom_we, 1);
    check("t6_addr", rom_addr, 0);
    check("t6_data", rom_data, 16'h1234);
`ifdef LOADER_CHECKSUM_EN
    send(8'h12);
    send(8'h34);
`endif
    set(1'b0, 8'h00, 1'b0);
    tick();
    check("t6_done", done, 1);
    check("t6_cpurst", cpu_reset, 0);
    reload();

`ifdef LOADER_CHECKSUM_EN
    // Checksum match then mismatch.
    bq = '{8'h00, 8'h02, 8'h00, 8'h02, 8'hEC, 8'h10, 8'hEC, 8'h12};
    foreach (bq[i]) send(bq[i]);
    set(1'b0, 8'h00, 1'b0);
    tick();
    check("ck_ok_done", done, 1);
    check("ck_ok_err", error, 0);
    reload();
    bq = '{8'h00, 8'h02, 8'h00, 8'h02, 8'hEC, 8'h10, 8'hEC, 8'h13};
    foreach (bq[i]) send(bq[i]);
    set(1'b0, 8'h00, 1'b0);
    tick();
    check("ck_bad_err", error, 1);
    check("ck_bad_cpurst", cpu_reset, 1);
    check("ck_bad_done", done, 0);
    reload();
`endif

    // Largest legal header 0x8000 = 2^15 enters DATA, not ERROR.
    send(8'h80);
    send(8'h00);
    set(1'b0, 8'h00, 1'b0);
    tick();
    check("t7_err", error, 0);
    check("t7_rdy", in_ready, 1);
    check("t7_cpurst", cpu_reset, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
